// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack -- program counter with a hardware return-address stack.
//
// Each enabled cycle performs exactly one action, highest priority first:
//   call > ret > load > rel > increment.
// A call pushes PC+1 and jumps to i_target. A ret pops the top entry into
// the PC. Calling with the stack full sets the sticky o_ovf flag. Returning
// with the stack empty sets the sticky o_unf flag. In both error cases the
// PC and the depth hold.
//
// Optional feature macro: PC_STACK_REL_BRANCH_EN
//   defined   : i_rel adds the sign-extended i_offset to the PC.
//   undefined : i_rel and i_offset are ignored, and no offset adder is built.
//
// Parameters
//   WIDTH     PC / address width in bits (2..16)
//   DEPTH     return-stack entries (1..16)
//   RESET_VEC PC value loaded on reset
//
// Ports
//   i_clk      clock; all state changes on the rising edge
//   i_rst      asynchronous, active-low reset
//   i_en       step enable; when low the PC, stack and depth hold
//   i_load     absolute jump to i_target
//   i_target   jump / call destination
//   i_call     push PC+1 and jump to i_target
//   i_ret      pop the top of stack into the PC
//   i_rel      relative branch by i_offset (feature macro only)
//   i_offset   two's-complement branch offset
//   i_clr_err  clear the sticky error flags
//   o_PC       current PC, driven straight from a register
//   o_depth    number of valid stack entries
//   o_ovf      sticky flag: call attempted with the stack full
//   o_unf      sticky flag: return attempted with the stack empty
// ---------------------------------------------------------------------------
module pc_stack #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_load,
  input  logic [WIDTH-1:0]           i_target,
  input  logic                       i_call,
  input  logic                       i_ret,
  input  logic                       i_rel,
  input  logic [WIDTH-1:0]           i_offset,
  input  logic                       i_clr_err,
  output logic [WIDTH-1:0]           o_PC,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_ovf,
  output logic                       o_unf
);

  localparam int unsigned   DW   = $clog2(DEPTH + 1);
  localparam int unsigned   SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, stack_top;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, unf_q;
  logic             push, ovf_set, unf_set;

  assign pc_inc    = pc_q + WIDTH'(1);
  assign stack_top = stack_mem[SW'(depth_q - DW'(1))];

`ifdef PC_STACK_REL_BRANCH_EN
  // Adding the offset at full width, modulo 2^WIDTH, is the same as
  // sign-extending it first.
  logic [WIDTH-1:0] pc_rel;
  assign pc_rel = pc_q + i_offset;
`else
  logic unused_rel;
  assign unused_rel = ^{i_rel, i_offset};
`endif

  // NOTE: every signal written in this block gets a default first, so no
  //       path through the if/else chain can leave one unassigned and
  //       infer a latch.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (i_en) begin
      if (i_call) begin
        if (depth_q == FULL) begin
          ovf_set = 1'b1;
        end else begin
          push    = 1'b1;
          pc_d    = i_target;
          depth_d = depth_q + DW'(1);
        end
      end else if (i_ret) begin
        if (depth_q == '0) begin
          unf_set = 1'b1;
        end else begin
          pc_d    = stack_top;
          depth_d = depth_q - DW'(1);
        end
      end else if (i_load) begin
        pc_d = i_target;
`ifdef PC_STACK_REL_BRANCH_EN
      end else if (i_rel) begin
        pc_d = pc_rel;
`endif
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  //       samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      // A new error in the same cycle wins over the clear.
      ovf_q   <= ovf_set | (ovf_q & ~i_clr_err);
      unf_q   <= unf_set | (unf_q & ~i_clr_err);
    end
  end

  // NOTE: the stack storage is deliberately not reset. o_depth alone
  //       decides which entries are valid, so clearing depth on reset
  //       discards the contents without touching the storage array.
  always_ff @(posedge i_clk) begin
    if (push) begin
      stack_mem[SW'(depth_q)] <= pc_inc;
    end
  end

  assign o_PC    = pc_q;
  assign o_depth = depth_q;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_stack -- scoreboard bench for pc_stack (WIDTH=8, DEPTH=4,
// RESET_VEC=0x10).
//
// The driver applies one action per cycle. It then advances a behavioural
// model and queues the expected outputs. The model uses an integer PC and a
// queue as the stack. A monitor pops one expectation after each rising edge
// and compares it against the DUT. Directed sequences also check literal
// values.
// ---------------------------------------------------------------------------
module tb_pc_stack;

  localparam int          W  = 8;
  localparam int          D  = 4;
  localparam logic [W-1:0] RV = 8'h10;
`ifdef PC_STACK_REL_BRANCH_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] pc;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
  logic         rel = 1'b0, clr = 1'b0;
  logic [W-1:0] target = '0, offset = '0;
  logic [W-1:0] pc;
  logic [2:0]   depth;
  logic         ovf, unf;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model state.
  int   m_pc = int'(RV);
  int   m_stack[$];
  bit   m_ovf = 1'b0, m_unf = 1'b0;

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_target(target),
    .i_call(call), .i_ret(ret), .i_rel(rel), .i_offset(offset),
    .i_clr_err(clr), .o_PC(pc), .o_depth(depth), .o_ovf(ovf), .o_unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model follows the rules directly. At most one action is taken.
  // An error leaves the PC and the stack alone. A flag is set by a new
  // error, or otherwise kept unless it is cleared.
  task automatic model_step(input bit e, c, r, l, rl, input int tgt, off,
                            input bit cl);
    bit new_ovf = 1'b0, new_unf = 1'b0;
    if (e) begin
      if (c) begin
        if (m_stack.size() == D) new_ovf = 1'b1;
        else begin
          m_stack.push_back((m_pc + 1) % 256);
          m_pc = tgt;
        end
      end else if (r) begin
        if (m_stack.size() == 0) new_unf = 1'b1;
        else m_pc = m_stack.pop_back();
      end else if (l) begin
        m_pc = tgt;
      end else if (rl && REL_EN) begin
        m_pc = (m_pc + ((off >= 128) ? off - 256 : off) + 256) % 256;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
    m_ovf = new_ovf || (m_ovf && !cl);
    m_unf = new_unf || (m_unf && !cl);
  endtask

  task automatic step(input bit e, c, r, l, rl, input logic [7:0] tgt, off,
                      input bit cl);
    exp_t x;
    @(negedge clk);
    en = e; call = c; ret = r; load = l; rel = rl;
    target = tgt; offset = off; clr = cl;
    model_step(e, c, r, l, rl, int'(tgt), int'(off), cl);
    x.pc    = 8'(m_pc);
    x.depth = 3'(m_stack.size());
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    sb_q.push_back(x);
    @(posedge clk);
    #3;
    en = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0; rel = 1'b0; clr = 1'b0;
  endtask

  // Monitor: one expectation is retired after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_pc", 32'(pc), 32'(e.pc));
        check("sb_depth", 32'(depth), 32'(e.depth));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
        check("sb_unf", 32'(unf), 32'(e.unf));
      end
    end
  end

  initial begin
    // Reset held across edges; release takes effect only at a clock edge.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'h10);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_flags", {30'b0, ovf, unf}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check("rel_pc0", 32'(pc), 32'h10);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0); check("inc1", 32'(pc), 32'h11);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0); check("inc2", 32'(pc), 32'h12);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0); check("inc3", 32'(pc), 32'h13);

    // Wrap: increment from 0xFF, and call from 0xFF pushes 0x00.
    step(1, 0, 0, 1, 0, 8'hFF, 8'h00, 0);
    step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0); check("wrap_inc", 32'(pc), 32'h00);
    step(1, 0, 0, 1, 0, 8'hFF, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h40, 8'h00, 0); check("wrap_call", 32'(pc), 32'h40);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0); check("wrap_ret", 32'(pc), 32'h00);

    // Nesting to full, overflow, then unwind.
    step(1, 0, 0, 1, 0, 8'h05, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h20, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h30, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h40, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h50, 8'h00, 0); check("nest_depth", 32'(depth), 32'h4);
    step(1, 1, 0, 0, 0, 8'h60, 8'h00, 0);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_pc", 32'(pc), 32'h50);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1); check("ovf_clr", 32'(ovf), 32'h0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0); check("ret1", 32'(pc), 32'h41);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0); check("ret2", 32'(pc), 32'h31);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0); check("ret3", 32'(pc), 32'h21);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0); check("ret4", 32'(pc), 32'h06);
    check("ret_depth", 32'(depth), 32'h0);

    // Underflow, clear, and clear racing a new underflow.
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0);
    check("unf_set", 32'(unf), 32'h1);
    check("unf_pc", 32'(pc), 32'h06);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1); check("unf_clr", 32'(unf), 32'h0);
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 1); check("unf_win", 32'(unf), 32'h1);

    // Priority, then all strobes with the enable low.
    step(1, 1, 0, 1, 1, 8'h77, 8'h05, 0);
    check("prio_pc", 32'(pc), 32'h77);
    check("prio_depth", 32'(depth), 32'h1);
    step(0, 1, 1, 1, 1, 8'h33, 8'h05, 0);
    check("dis_pc", 32'(pc), 32'h77);
    check("dis_depth", 32'(depth), 32'h1);

    // Relative branch with a negative offset, including wrap below zero.
    step(1, 0, 0, 1, 0, 8'h10, 8'h00, 0);
    step(1, 0, 0, 0, 1, 8'h00, 8'hFC, 0);
    check("rel_neg", 32'(pc), REL_EN ? 32'h0C : 32'h11);
    step(1, 0, 0, 1, 0, 8'h02, 8'h00, 0);
    step(1, 0, 0, 0, 1, 8'h00, 8'hFC, 0);
    check("rel_wrap", 32'(pc), REL_EN ? 32'hFE : 32'h03);

    // Asynchronous reset in the middle of a call chain.
    step(1, 1, 0, 0, 0, 8'h80, 8'h00, 0);
    step(1, 1, 0, 0, 0, 8'h90, 8'h00, 0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'h10);
    check("arst_depth", 32'(depth), 32'h0);
    check("arst_flags", {30'b0, ovf, unf}, 32'h0);
    m_pc = int'(RV);
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 0);
    check("arst_unf", 32'(unf), 32'h1);
    check("arst_unf_pc", 32'(pc), 32'h10);

    // Random traffic checked only through the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 85, $urandom_range(99) < 25,
           $urandom_range(99) < 25, $urandom_range(99) < 15,
           $urandom_range(99) < 25, 8'($urandom), 8'($urandom),
           $urandom_range(99) < 10);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 8, PC and address width in bits (2..16).
REQ-002 Parameter DEPTH, default 4, return-stack entries (1..16).
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-low reset.
REQ-006 i_en  input  1  step enable; no PC or stack change when low.
REQ-007 i_load  input  1  absolute jump strobe.
REQ-008 i_target  input  WIDTH  jump/call destination.
REQ-009 i_call  input  1  subroutine call strobe (push PC+1, jump to i_target).
REQ-010 i_ret  input  1  return strobe (pop stack into PC).
REQ-011 i_rel  input  1  relative branch strobe.
REQ-012 i_offset  input  WIDTH  two's-complement branch offset.
REQ-013 i_clr_err  input  1  clears sticky error flags.
REQ-014 o_PC  output  WIDTH  current program counter, driven directly from a register.
REQ-015 o_depth  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-016 o_ovf  output  1  sticky: call attempted with stack full.
REQ-017 o_unf  output  1  sticky: return attempted with stack empty.

Function
REQ-018 With i_en high, exactly one action per cycle; priority: i_call > i_ret > i_load > i_rel > increment.
REQ-019 Increment (i_en high, no strobe): PC <= PC+1 modulo 2^WIDTH; 2^WIDTH-1 wraps to 0.
REQ-020 Load: PC <= i_target next edge; stack untouched.
REQ-021 Rel: PC <= PC + sign-extended i_offset, modulo 2^WIDTH; offset 0 leaves PC unchanged.
REQ-022 Call, stack not full: push (PC+1 mod 2^WIDTH), PC <= i_target, o_depth+1, same edge.
REQ-023 Call, stack full (o_depth==DEPTH): no push, PC and depth unchanged, o_ovf <= 1.
REQ-024 Ret, stack not empty: PC <= top entry, o_depth-1, same edge.
REQ-025 Ret, stack empty: PC and depth unchanged, o_unf <= 1.
REQ-026 Stack is LIFO; entries beyond o_depth are don't-care and never observable.
REQ-027 i_en low: all strobes ignored; PC, stack, depth hold; flags still clearable.
REQ-028 i_clr_err clears o_ovf/o_unf next edge; a same-cycle new error wins (flag sets).
REQ-029 Single-cycle latency for every action; no combinational path input -> o_PC.

Reset
REQ-030 i_rst low asynchronously forces o_PC=RESET_VEC, o_depth=0, o_ovf=0, o_unf=0.
REQ-031 Reset mid-call-chain discards all stack contents; first ret after reset sets o_unf.
REQ-032 Reset release is sampled at i_clk; first action occurs on the first edge with i_rst high.

Configuration
REQ-033 Macro PC_STACK_REL_BRANCH_EN defined: i_rel/i_offset function per REQ-021.
REQ-034 Macro undefined: i_rel and i_offset ports remain but are ignored; i_rel cycle behaves as increment (if no higher strobe); no adder for offset is synthesised.

Verification
REQ-035 Reset: RESET_VEC=0x10, release, i_en=1 for 3 cycles -> o_PC 0x10,0x11,0x12,0x13.
REQ-036 Wrap: WIDTH=8, load 0xFF, one increment -> o_PC=0x00; call at PC 0xFF to 0x40 -> pushed 0x00, ret -> o_PC=0x00.
REQ-037 Nesting: DEPTH=4, PC=0x05, calls to 0x20,0x30,0x40,0x50 -> depth 4; fifth call -> o_ovf=1, PC stays 0x50; four rets -> PC 0x41,0x31,0x21,0x06, depth 0.
REQ-038 Underflow: depth 0, ret -> o_unf=1, PC unchanged; i_clr_err -> o_unf=0; i_clr_err with ret same cycle -> o_unf stays 1.
REQ-039 Priority/enable: i_call+i_load+i_rel together -> call taken; all strobes with i_en=0 -> no change.
REQ-040 Relative (macro on): PC=0x10, i_offset=0xFC -> 0x0C; PC=0x02, offset 0xFC -> 0xFE; macro off: same stimulus -> PC 0x11.
